// File: rtl/imsic_msi_rx_if.sv
// ---------------------------------------------------------------------------
// imsic_msi_rx_if
// MSI info bus between the IMSIC register map (MMIO clock) and the per-hart
// CSR-domain receiver. The register map drives it; the receiver samples it.
//
// Signals
//   msi_info      INFO_W  {hart, file, id}, id at LSBs; held stable by the
//                         source while a message is in flight
//   msi_info_vld  1       level, high for >= 2 receiver clk periods per message
//
// Modports
//   master  register-map side (drives the bus)
//   slave   receiver side (samples the bus)
// ---------------------------------------------------------------------------
interface imsic_msi_rx_if #(
    parameter int INFO_W = 14
);
    logic [INFO_W-1:0] msi_info;
    logic              msi_info_vld;

    modport master (output msi_info, output msi_info_vld);
    modport slave  (input  msi_info, input  msi_info_vld);
endinterface

// File: rtl/imsic_msi_rx.sv
// ---------------------------------------------------------------------------
// imsic_msi_rx
// CSR-clock-domain receiver for the IMSIC MSI info bus. Synchronises the
// asynchronous valid level, captures the info word once per message, filters
// it against this hart and sets the pending bit of the addressed interrupt
// file. The CSR/topei logic reads o_eip and clears bits on claim.
//
// Ports
//   clk           in   CSR clock
//   rstn          in   asynchronous active-low reset
//   hart_id       in   static index of this hart
//   i_msi         in   MSI info bus (slave modport of imsic_msi_rx_if)
//   clr_vld       in   claim: clear one pending bit this cycle
//   clr_file      in   file of the bit to clear
//   clr_id        in   identity of the bit to clear
//   o_eip         out  pending bits, file f id i at bit f*NR_SRC+i
//   o_setip_we    out  one-cycle pulse per accepted message
//   o_setip_file  out  file of the last accepted message
//   o_setip_id    out  identity of the last accepted message
//   o_drop_cnt    out  saturating count of rejected messages
// ---------------------------------------------------------------------------
module imsic_msi_rx #(
    parameter int NR_SRC_WIDTH    = 5,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int NR_HARTS_WIDTH  = 6,
    parameter int NR_INTP_FILES   = 7
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [NR_HARTS_WIDTH-1:0]                    hart_id,
    imsic_msi_rx_if.slave                                i_msi,
    input  logic                                         clr_vld,
    input  logic [INTP_FILE_WIDTH-1:0]                   clr_file,
    input  logic [NR_SRC_WIDTH-1:0]                      clr_id,
    output logic [NR_INTP_FILES*(2**NR_SRC_WIDTH)-1:0]   o_eip,
    output logic                                         o_setip_we,
    output logic [INTP_FILE_WIDTH-1:0]                   o_setip_file,
    output logic [NR_SRC_WIDTH-1:0]                      o_setip_id,
    output logic [7:0]                                   o_drop_cnt
);
    localparam int NR_SRC = 2**NR_SRC_WIDTH;
    localparam int INFO_W = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH;
    localparam int EIP_W  = NR_INTP_FILES * NR_SRC;
    // One extra bit so the file-range compare cannot wrap.
    localparam logic [INTP_FILE_WIDTH:0] FILES_LIM = (INTP_FILE_WIDTH+1)'(NR_INTP_FILES);

    logic                       r_vld_s1;
    logic                       r_vld_s2;
    logic                       r_vld_s3;
    logic [INFO_W-1:0]          r_info_q;
    logic                       r_cap_vld;
    logic                       r_setip_we;
    logic [INTP_FILE_WIDTH-1:0] r_setip_file;
    logic [NR_SRC_WIDTH-1:0]    r_setip_id;
    logic [7:0]                 r_drop_cnt;
    logic [EIP_W-1:0]           r_eip;

    logic                       w_rise;
    logic [NR_HARTS_WIDTH-1:0]  w_info_hart;
    logic [INTP_FILE_WIDTH-1:0] w_info_file;
    logic [NR_SRC_WIDTH-1:0]    w_info_id;
    logic                       w_accept;
    logic [EIP_W-1:0]           w_eip_next;

    // Rising edge of the synchronised valid marks exactly one message.
    assign w_rise      = r_vld_s2 & ~r_vld_s3;

    assign w_info_hart = r_info_q[INFO_W-1 -: NR_HARTS_WIDTH];
    assign w_info_file = r_info_q[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
    assign w_info_id   = r_info_q[NR_SRC_WIDTH-1:0];
    assign w_accept    = (w_info_hart == hart_id)
                       & ({1'b0, w_info_file} < FILES_LIM)
                       & (w_info_id != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_s1     <= 1'b0;
            r_vld_s2     <= 1'b0;
            r_vld_s3     <= 1'b0;
            r_info_q     <= '0;
            r_cap_vld    <= 1'b0;
            r_setip_we   <= 1'b0;
            r_setip_file <= '0;
            r_setip_id   <= '0;
            r_drop_cnt   <= 8'd0;
            r_eip        <= '0;
        end else begin
            r_vld_s1  <= i_msi.msi_info_vld;
            r_vld_s2  <= r_vld_s1;
            r_vld_s3  <= r_vld_s2;
            // The multi-bit info word is only sampled here: the source keeps it
            // stable well past the valid rise, so it is settled by now.
            if (w_rise) begin
                r_info_q <= i_msi.msi_info;
            end
            r_cap_vld  <= w_rise;

            r_setip_we <= r_cap_vld & w_accept;
            if (r_cap_vld & w_accept) begin
                r_setip_file <= w_info_file;
                r_setip_id   <= w_info_id;
            end
            if (r_cap_vld & ~w_accept & (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            r_eip <= w_eip_next;
        end
    end

    // Per-bit pending update. A set and a clear of the same bit in one cycle
    // keeps the bit set so a fresh message is never lost to a stale claim.
    // Clears aimed at a non-existent file or at identity 0 match no bit.
    genvar gi;
    generate
        for (gi = 0; gi < EIP_W; gi++) begin : g_eip
            localparam int FILE_IDX = gi / NR_SRC;
            localparam int ID_IDX   = gi % NR_SRC;
            logic w_set;
            logic w_clr;
            assign w_set = r_setip_we
                         & (r_setip_file == INTP_FILE_WIDTH'(FILE_IDX))
                         & (r_setip_id   == NR_SRC_WIDTH'(ID_IDX));
            assign w_clr = clr_vld
                         & (clr_file == INTP_FILE_WIDTH'(FILE_IDX))
                         & (clr_id   == NR_SRC_WIDTH'(ID_IDX))
                         & (clr_id   != '0);
            assign w_eip_next[gi] = w_set | (r_eip[gi] & ~w_clr);
        end
    endgenerate

    assign o_eip        = r_eip;
    assign o_setip_we   = r_setip_we;
    assign o_setip_file = r_setip_file;
    assign o_setip_id   = r_setip_id;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_imsic_msi_rx.sv
// ---------------------------------------------------------------------------
// tb_imsic_msi_rx
// Directed testbench for imsic_msi_rx: reset values, exact set-pulse latency,
// hart/file/id filtering with drop counting, set/clear collisions, an
// asynchronous back-to-back source, drop-count saturation and async reset.
// ---------------------------------------------------------------------------
module tb_imsic_msi_rx;
    localparam int HW     = 6;
    localparam int FW     = 3;
    localparam int SW     = 5;
    localparam int NF     = 7;
    localparam int INFO_W = HW + FW + SW;
    localparam int EIP_W  = NF * 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [HW-1:0]     hart_id = 6'd3;
    logic              clr_vld = 1'b0;
    logic [FW-1:0]     clr_file = '0;
    logic [SW-1:0]     clr_id = '0;
    logic [EIP_W-1:0]  o_eip;
    logic              o_setip_we;
    logic [FW-1:0]     o_setip_file;
    logic [SW-1:0]     o_setip_id;
    logic [7:0]        o_drop_cnt;

    imsic_msi_rx_if #(.INFO_W(INFO_W)) msi_if ();

    imsic_msi_rx #(
        .NR_SRC_WIDTH    (SW),
        .INTP_FILE_WIDTH (FW),
        .NR_HARTS_WIDTH  (HW),
        .NR_INTP_FILES   (NF)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .hart_id      (hart_id),
        .i_msi        (msi_if),
        .clr_vld      (clr_vld),
        .clr_file     (clr_file),
        .clr_id       (clr_id),
        .o_eip        (o_eip),
        .o_setip_we   (o_setip_we),
        .o_setip_file (o_setip_file),
        .o_setip_id   (o_setip_id),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [EIP_W-1:0] exp_eip = '0;

    // Each cycle with the pulse high is seen once, at the edge that ends it.
    always @(posedge clk) begin
        if (o_setip_we) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [INFO_W-1:0] mk(input int h, input int f, input int i);
        logic [HW-1:0] hh;
        logic [FW-1:0] ff;
        logic [SW-1:0] ii;
        hh = HW'(h);
        ff = FW'(f);
        ii = SW'(i);
        return {hh, ff, ii};
    endfunction

    // Clock-aligned message: valid high for 2 clk, then 4 clk of settle time.
    task automatic send_sync(input logic [INFO_W-1:0] info);
        @(negedge clk);
        msi_if.msi_info     = info;
        msi_if.msi_info_vld = 1'b1;
        repeat (2) @(negedge clk);
        msi_if.msi_info_vld = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Message from a source clocked at ~1.7x clk (6 ns): 4 src cycles high,
    // 4 src cycles low, edges deliberately off the clk grid.
    task automatic send_async(input logic [INFO_W-1:0] info);
        #3;
        msi_if.msi_info     = info;
        msi_if.msi_info_vld = 1'b1;
        #24;
        msi_if.msi_info_vld = 1'b0;
        #24;
    endtask

    // Clock-aligned message with a claim driven during the cycle in which
    // o_setip_we is high; returns 1 ns after the edge that applies both.
    task automatic send_with_clr(input string tag, input logic [INFO_W-1:0] info,
                                 input logic [FW-1:0] cf, input logic [SW-1:0] ci);
        @(negedge clk);
        msi_if.msi_info     = info;
        msi_if.msi_info_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        msi_if.msi_info_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(tag, 256'(o_setip_we), 256'(1));
        clr_vld  = 1'b1;
        clr_file = cf;
        clr_id   = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        msi_if.msi_info     = '0;
        msi_if.msi_info_vld = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_eip",  256'(o_eip), 256'(0));
        check("rst_we",   256'(o_setip_we), 256'(0));
        check("rst_drop", 256'(o_drop_cnt), 256'(0));
        check("rst_file", 256'(o_setip_file), 256'(0));
        check("rst_id",   256'(o_setip_id), 256'(0));

        // 1: exact latency, valid sampled high at edge N -> pulse N+3..N+4.
        @(negedge clk);
        msi_if.msi_info     = mk(3, 1, 5);
        msi_if.msi_info_vld = 1'b1;
        @(posedge clk); #1;
        check("t1_we_n0", 256'(o_setip_we), 256'(0));
        @(posedge clk); #1;
        check("t1_we_n1", 256'(o_setip_we), 256'(0));
        @(negedge clk);
        msi_if.msi_info_vld = 1'b0;
        @(posedge clk); #1;
        check("t1_we_n2", 256'(o_setip_we), 256'(0));
        @(posedge clk); #1;
        check("t1_we_n3",   256'(o_setip_we), 256'(1));
        check("t1_file",    256'(o_setip_file), 256'(1));
        check("t1_id",      256'(o_setip_id), 256'(5));
        check("t1_eip_n3",  256'(o_eip), 256'(exp_eip));
        exp_eip[1*32+5] = 1'b1;
        @(posedge clk); #1;
        check("t1_we_n4",   256'(o_setip_we), 256'(0));
        check("t1_eip_n4",  256'(o_eip), 256'(exp_eip));
        check("t1_drop",    256'(o_drop_cnt), 256'(0));
        check("t1_pulses",  256'(pulse_cnt), 256'(1));
        repeat (3) @(negedge clk);

        // 2: rejected messages (wrong hart, file 7, id 0).
        send_sync(mk(4, 0, 7));
        check("t2_drop1",   256'(o_drop_cnt), 256'(1));
        check("t2_eip1",    256'(o_eip), 256'(exp_eip));
        send_sync(mk(3, 7, 2));
        send_sync(mk(3, 2, 0));
        check("t2_drop3",   256'(o_drop_cnt), 256'(3));
        check("t2_pulses",  256'(pulse_cnt), 256'(1));
        check("t2_eip3",    256'(o_eip), 256'(exp_eip));
        check("t2_hold_f",  256'(o_setip_file), 256'(1));
        check("t2_hold_id", 256'(o_setip_id), 256'(5));

        // 3: set/clear collisions.
        send_sync(mk(3, 0, 9));
        exp_eip[9] = 1'b1;
        check("t3_set9", 256'(o_eip), 256'(exp_eip));
        send_with_clr("t3_we_same", mk(3, 0, 9), 3'd0, 5'd9);
        check("t3_same_set_wins", 256'(o_eip), 256'(exp_eip));
        @(posedge clk); #1;
        exp_eip[9] = 1'b0;
        check("t3_clr_alone", 256'(o_eip), 256'(exp_eip));
        @(negedge clk);
        clr_vld = 1'b0;
        send_with_clr("t3_we_diff", mk(3, 3, 3), 3'd1, 5'd5);
        exp_eip[3*32+3] = 1'b1;
        exp_eip[1*32+5] = 1'b0;
        check("t3_diff_both", 256'(o_eip), 256'(exp_eip));
        @(negedge clk);
        clr_vld = 1'b0;
        send_with_clr("t3_we_reset", mk(3, 3, 3), 3'd0, 5'd0);
        check("t3_reset_nodrop", 256'(o_drop_cnt), 256'(3));
        check("t3_reset_eip", 256'(o_eip), 256'(exp_eip));
        @(negedge clk);
        clr_vld = 1'b1;
        clr_file = 3'd7;
        clr_id = 5'd3;
        @(negedge clk);
        clr_vld = 1'b0;
        check("t3_clr_badfile", 256'(o_eip), 256'(exp_eip));
        check("t3_pulses", 256'(pulse_cnt), 256'(5));

        // 4: back-to-back messages from an asynchronous source.
        send_async(mk(3, 0, 1));
        send_async(mk(3, 6, 31));
        repeat (6) @(negedge clk);
        exp_eip[1] = 1'b1;
        exp_eip[6*32+31] = 1'b1;
        check("t4_eip",    256'(o_eip), 256'(exp_eip));
        check("t4_pulses", 256'(pulse_cnt), 256'(7));
        check("t4_drop",   256'(o_drop_cnt), 256'(3));
        check("t4_hold_f", 256'(o_setip_file), 256'(6));
        check("t4_hold_id",256'(o_setip_id), 256'(31));

        // 5: drop counter saturation.
        for (int k = 0; k < 251; k++) send_sync(mk(5, 1, 1));
        check("t5_drop254", 256'(o_drop_cnt), 256'(254));
        send_sync(mk(3, 0, 0));
        check("t5_drop255", 256'(o_drop_cnt), 256'(255));
        for (int k = 0; k < 3; k++) send_sync(mk(3, 7, 1));
        check("t5_drop_sat", 256'(o_drop_cnt), 256'(255));
        check("t5_pulses",   256'(pulse_cnt), 256'(7));
        check("t5_eip",      256'(o_eip), 256'(exp_eip));

        // Asynchronous reset in the middle of synchronisation.
        @(negedge clk);
        msi_if.msi_info     = mk(3, 2, 4);
        msi_if.msi_info_vld = 1'b1;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_eip = '0;
        check("rst2_eip",  256'(o_eip), 256'(0));
        check("rst2_we",   256'(o_setip_we), 256'(0));
        check("rst2_drop", 256'(o_drop_cnt), 256'(0));
        check("rst2_file", 256'(o_setip_file), 256'(0));
        check("rst2_id",   256'(o_setip_id), 256'(0));
        @(negedge clk);
        rstn = 1'b1;
        // Valid still high at release: seen as one new message.
        repeat (2) @(negedge clk);
        msi_if.msi_info_vld = 1'b0;
        repeat (4) @(negedge clk);
        exp_eip[2*32+4] = 1'b1;
        check("rst2_msg_eip",    256'(o_eip), 256'(exp_eip));
        check("rst2_msg_pulses", 256'(pulse_cnt), 256'(8));
        check("rst2_msg_file",   256'(o_setip_file), 256'(2));
        check("rst2_msg_id",     256'(o_setip_id), 256'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
